// File: rtl/test_pseudo_compressed_decoder_lat.sv
// Pseudo compressed decoder: expands RVC c.addi/c.li/c.slli into RV32I with programmable response delay.
// Latency: Latency cycles from request sampling to ready (0 = same-cycle, combinational).
// Backpressure: ready pulses once per request; a dropped or re-tagged request aborts and restarts the wait.
module test_pseudo_compressed_decoder_lat #(
    parameter int unsigned Latency  = 2,
    parameter logic [2:0]  InstrEn  = 3'b111,
    parameter logic [3:0]  ModeMask = 4'b1111,
    parameter int unsigned CntWidth = 16,
    parameter int unsigned XIdWidth = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     x_compressed_valid_i,
    output logic                     x_compressed_ready_o,
    // request layout: {instr[15:0], mode[1:0], id[XIdWidth-1:0]}
    input  logic [XIdWidth+17:0]     x_compressed_req_i,
    // response layout: {instr[31:0], accept}
    output logic [32:0]              x_compressed_resp_o,
    output logic [CntWidth-1:0]      num_accept_o,
    output logic [CntWidth-1:0]      num_reject_o
);

    localparam logic [6:0] OPCODE_OP_IMM = 7'h13;

    logic [15:0]         c_instr;
    logic [1:0]          req_mode;
    logic [XIdWidth-1:0] req_id;
    logic [11:0]         imm12;
    logic [31:0]         dec_instr;
    logic                dec_accept;
    logic [32:0]         dec_resp;
    logic                handshake;

    assign c_instr  = x_compressed_req_i[XIdWidth+17 -: 16];
    assign req_mode = x_compressed_req_i[XIdWidth+1 -: 2];
    assign req_id   = x_compressed_req_i[XIdWidth-1:0];
    assign imm12    = {{6{c_instr[12]}}, c_instr[12], c_instr[6:2]};

    always_comb begin
        dec_instr  = '0;
        dec_accept = 1'b0;
        if (ModeMask[req_mode]) begin
            if (c_instr[1:0] == 2'b01 && c_instr[15:13] == 3'b000 && InstrEn[0]) begin
                dec_instr  = {imm12, c_instr[11:7], 3'b000, c_instr[11:7], OPCODE_OP_IMM};
                dec_accept = 1'b1;
            end else if (c_instr[1:0] == 2'b01 && c_instr[15:13] == 3'b010 && InstrEn[1]) begin
                dec_instr  = {imm12, 5'd0, 3'b000, c_instr[11:7], OPCODE_OP_IMM};
                dec_accept = 1'b1;
            end else if (c_instr[1:0] == 2'b10 && c_instr[15:13] == 3'b000 && InstrEn[2]
                         && !c_instr[12]) begin
                // shamt[5] set is illegal on RV32, so only c[12]==0 expands
                dec_instr  = {7'd0, c_instr[6:2], c_instr[11:7], 3'b001, c_instr[11:7], OPCODE_OP_IMM};
                dec_accept = 1'b1;
            end
        end
    end

    assign dec_resp  = {dec_instr, dec_accept};
    assign handshake = x_compressed_valid_i & x_compressed_ready_o;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            num_accept_o <= '0;
            num_reject_o <= '0;
        end else if (handshake) begin
            if (x_compressed_resp_o[0]) begin
                if (num_accept_o != {CntWidth{1'b1}}) num_accept_o <= num_accept_o + 1'b1;
            end else begin
                if (num_reject_o != {CntWidth{1'b1}}) num_reject_o <= num_reject_o + 1'b1;
            end
        end
    end

    generate
        if (Latency == 0) begin : g_comb
            assign x_compressed_ready_o = x_compressed_valid_i;
            assign x_compressed_resp_o  = dec_resp;
        end else begin : g_fsm
            typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
            localparam logic [3:0] LOAD = 4'(Latency - 1);

            state_t              state;
            logic [3:0]          cnt;
            logic [XIdWidth-1:0] cap_id;
            logic [32:0]         resp_q;
            logic                id_match;
            logic                capture;

            assign id_match = (req_id == cap_id);
            // fresh request in IDLE, or a replacing request while one is pending
            assign capture  = x_compressed_valid_i && (state == IDLE || !id_match);

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    state  <= IDLE;
                    cnt    <= '0;
                    cap_id <= '0;
                    resp_q <= '0;
                end else if (capture) begin
                    resp_q <= dec_resp;
                    cap_id <= req_id;
                    cnt    <= LOAD;
                    state  <= (Latency == 1) ? RESP : WAIT;
                end else begin
                    case (state)
                        WAIT: begin
                            if (!x_compressed_valid_i) begin
                                state <= IDLE;
                            end else begin
                                cnt <= cnt - 1'b1;
                                if (cnt == 4'd1) state <= RESP;
                            end
                        end
                        RESP:    state <= IDLE;
                        default: state <= IDLE;
                    endcase
                end
            end

            assign x_compressed_ready_o = (state == RESP) && x_compressed_valid_i && id_match;
            assign x_compressed_resp_o  = resp_q;
        end
    endgenerate

endmodule

// File: tb/tb_test_pseudo_compressed_decoder_lat.sv
// Bench for test_pseudo_compressed_decoder_lat: four configurations driven side by side,
// checked against a request-age model and an arithmetic decode reference.
module tb_test_pseudo_compressed_decoder_lat;

    localparam int N  = 4;
    localparam int XW = 4;
    localparam int          LAT [N] = '{2, 0, 3, 1};
    localparam logic [2:0]  IEN [N] = '{3'b111, 3'b111, 3'b001, 3'b110};
    localparam logic [3:0]  MMK [N] = '{4'b1111, 4'b1111, 4'b1000, 4'b0101};
    localparam int          CWD [N] = '{16, 16, 2, 4};

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          vld [N];
    logic [15:0]   ins [N];
    logic [1:0]    mde [N];
    logic [XW-1:0] idv [N];
    logic          rdy [N];
    logic [32:0]   rsp [N];
    logic [15:0]   na  [N];
    logic [15:0]   nr  [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            logic [CWD[g]-1:0] a_cnt;
            logic [CWD[g]-1:0] r_cnt;
            test_pseudo_compressed_decoder_lat #(
                .Latency (LAT[g]),
                .InstrEn (IEN[g]),
                .ModeMask(MMK[g]),
                .CntWidth(CWD[g]),
                .XIdWidth(XW)
            ) u_dut (
                .clk_i               (clk_i),
                .rst_ni              (rst_ni),
                .x_compressed_valid_i(vld[g]),
                .x_compressed_ready_o(rdy[g]),
                .x_compressed_req_i  ({ins[g], mde[g], idv[g]}),
                .x_compressed_resp_o (rsp[g]),
                .num_accept_o        (a_cnt),
                .num_reject_o        (r_cnt)
            );
            assign na[g] = 16'(a_cnt);
            assign nr[g] = 16'(r_cnt);
        end
    endgenerate

    // Model: a pending request remembers its id, its decoded response and how many edges ago it was taken.
    bit          m_busy [N];
    logic [XW-1:0] m_id [N];
    int          m_age  [N];
    logic [32:0] m_resp [N];
    int          m_na   [N];
    int          m_nr   [N];
    bit          e_hs   [N];
    bit          e_acc  [N];

    int n_cmp = 0;
    int n_err = 0;

    function automatic logic [32:0] ref_dec(logic [15:0] c, logic [1:0] m, logic [2:0] en, logic [3:0] mm);
        int          imm;
        logic [11:0] i12;
        logic [4:0]  rd;
        logic [31:0] r;
        rd  = c[11:7];
        imm = int'({c[12], c[6:2]}) - (c[12] ? 64 : 0);
        i12 = imm[11:0];
        if (!mm[m]) return 33'd0;
        if (c[1:0] == 2'b01 && c[15:13] == 3'd0 && en[0])
            r = {i12, rd, 3'b000, rd, 7'h13};
        else if (c[1:0] == 2'b01 && c[15:13] == 3'd2 && en[1])
            r = {i12, 5'd0, 3'b000, rd, 7'h13};
        else if (c[1:0] == 2'b10 && c[15:13] == 3'd0 && en[2] && !c[12])
            r = {7'd0, c[6:2], rd, 3'b001, rd, 7'h13};
        else
            return 33'd0;
        return {r, 1'b1};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < N; g++) begin
            m_busy[g] = 0; m_id[g] = '0; m_age[g] = 0; m_resp[g] = '0;
            m_na[g] = 0; m_nr[g] = 0;
        end
    endtask

    task automatic settle();
        logic [32:0] er;
        #1;
        for (int g = 0; g < N; g++) begin
            if (LAT[g] == 0) begin
                e_hs[g] = vld[g];
                er      = ref_dec(ins[g], mde[g], IEN[g], MMK[g]);
            end else begin
                e_hs[g] = m_busy[g] && vld[g] && (idv[g] == m_id[g]) && (m_age[g] == LAT[g]);
                er      = m_resp[g];
            end
            e_acc[g] = er[0];
            chk($sformatf("ready[%0d]", g), 64'(rdy[g]), 64'(e_hs[g]));
            if (e_hs[g]) chk($sformatf("resp[%0d]", g), 64'(rsp[g]), 64'(er));
            chk($sformatf("num_accept[%0d]", g), 64'(na[g]), 64'(m_na[g]));
            chk($sformatf("num_reject[%0d]", g), 64'(nr[g]), 64'(m_nr[g]));
        end
    endtask

    task automatic advance();
        int top;
        @(posedge clk_i);
        for (int g = 0; g < N; g++) begin
            top = (1 << CWD[g]) - 1;
            if (e_hs[g]) begin
                if (e_acc[g]) m_na[g] = (m_na[g] < top) ? m_na[g] + 1 : top;
                else          m_nr[g] = (m_nr[g] < top) ? m_nr[g] + 1 : top;
            end
            if (LAT[g] != 0) begin
                if (vld[g] && (!m_busy[g] || idv[g] != m_id[g])) begin
                    m_busy[g] = 1; m_id[g] = idv[g]; m_age[g] = 1;
                    m_resp[g] = ref_dec(ins[g], mde[g], IEN[g], MMK[g]);
                end else if (m_busy[g]) begin
                    if (!vld[g] || m_age[g] == LAT[g]) m_busy[g] = 0;
                    else                               m_age[g]++;
                end
            end
        end
        @(negedge clk_i);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            settle();
            advance();
        end
    endtask

    task automatic drive(input int g, input logic v, input logic [15:0] c, input logic [1:0] m,
                         input logic [XW-1:0] id);
        vld[g] = v; ins[g] = c; mde[g] = m; idv[g] = id;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] x;
        int          k;
        x = 16'($urandom);
        k = $urandom_range(0, 5);
        x[1:0] = (k == 0) ? 2'b11 : (k < 3) ? 2'b10 : 2'b01;
        k = $urandom_range(0, 3);
        if (k == 0)      x[15:13] = 3'd0;
        else if (k == 1) x[15:13] = 3'd2;
        else if (k == 2) x[15:13] = 3'd0;
        return x;
    endfunction

    initial begin
        for (int g = 0; g < N; g++) drive(g, 1'b0, 16'h0, 2'd0, '0);
        model_reset();
        rst_ni = 1'b0;

        // reset state
        @(negedge clk_i);
        #1;
        for (int g = 0; g < N; g++) begin
            chk($sformatf("rst_ready[%0d]", g), 64'(rdy[g]), 64'd0);
            chk($sformatf("rst_resp[%0d]", g), 64'(rsp[g]), 64'd0);
            chk($sformatf("rst_na[%0d]", g), 64'(na[g]), 64'd0);
            chk($sformatf("rst_nr[%0d]", g), 64'(nr[g]), 64'd0);
        end
        @(negedge clk_i);
        rst_ni = 1'b1;
        steps(1);

        // Latency 2: c.addi x10,1 held valid -> ready two cycles after sampling
        drive(0, 1'b1, 16'h0505, 2'd3, 4'd1);
        steps(1);
        settle();
        chk("lat2_early_ready", 64'(rdy[0]), 64'd0);
        advance();
        settle();
        chk("lat2_ready", 64'(rdy[0]), 64'd1);
        chk("lat2_addi_instr", 64'(rsp[0][32:1]), 64'h00150513);
        chk("lat2_addi_accept", 64'(rsp[0][0]), 64'd1);
        advance();
        drive(0, 1'b0, 16'h0505, 2'd3, 4'd1);
        settle();
        chk("lat2_ready_once", 64'(rdy[0]), 64'd0);
        chk("lat2_num_accept", 64'(na[0]), 64'd1);
        advance();

        // Latency 0: same-cycle ready, c.li and both c.slli forms
        drive(1, 1'b1, 16'h4529, 2'd0, 4'd0);
        settle();
        chk("lat0_ready", 64'(rdy[1]), 64'd1);
        chk("lat0_li_instr", 64'(rsp[1][32:1]), 64'h00A00513);
        chk("lat0_li_accept", 64'(rsp[1][0]), 64'd1);
        advance();
        drive(1, 1'b1, 16'h1502, 2'd0, 4'd1);
        settle();
        chk("slli_shamt32_resp", 64'(rsp[1]), 64'd0);
        advance();
        drive(1, 1'b1, 16'h050A, 2'd0, 4'd2);
        settle();
        chk("slli_instr", 64'(rsp[1][32:1]), 64'h00251513);
        chk("slli_accept", 64'(rsp[1][0]), 64'd1);
        advance();
        drive(1, 1'b0, 16'h0, 2'd0, 4'd0);
        settle();
        chk("lat0_num_reject", 64'(nr[1]), 64'd1);
        chk("lat0_num_accept", 64'(na[1]), 64'd2);
        advance();

        // Latency 3, ModeMask 1000, InstrEn 001: mode and enable filtering
        drive(2, 1'b1, 16'h0505, 2'd0, 4'd2);
        steps(3);
        settle();
        chk("mode0_accept", 64'(rsp[2][0]), 64'd0);
        advance();
        drive(2, 1'b0, 16'h0505, 2'd0, 4'd2);
        steps(1);
        drive(2, 1'b1, 16'h0505, 2'd3, 4'd3);
        steps(3);
        settle();
        chk("mode3_accept", 64'(rsp[2][0]), 64'd1);
        advance();
        drive(2, 1'b0, 16'h0505, 2'd3, 4'd3);
        steps(1);
        drive(2, 1'b1, 16'h4529, 2'd3, 4'd4);
        steps(3);
        settle();
        chk("li_disabled_accept", 64'(rsp[2][0]), 64'd0);
        advance();
        drive(2, 1'b0, 16'h4529, 2'd3, 4'd4);
        steps(1);

        // withdraw during WAIT: no ready, no count
        drive(2, 1'b1, 16'h0505, 2'd3, 4'd5);
        steps(1);
        drive(2, 1'b0, 16'h0505, 2'd3, 4'd5);
        steps(4);
        settle();
        chk("withdraw_num_accept", 64'(na[2]), 64'd1);
        advance();

        // replace id during WAIT: ready three cycles after the change, new response
        drive(2, 1'b1, 16'h0505, 2'd3, 4'd6);
        steps(2);
        drive(2, 1'b1, 16'h0509, 2'd3, 4'd7);
        steps(3);
        settle();
        chk("replace_ready", 64'(rdy[2]), 64'd1);
        chk("replace_instr", 64'(rsp[2][32:1]), 64'h00250513);
        advance();
        drive(2, 1'b0, 16'h0509, 2'd3, 4'd7);
        steps(1);

        // saturation of the 2-bit accept counter
        for (int k = 0; k < 3; k++) begin
            drive(2, 1'b1, 16'h0505, 2'd3, 4'(8 + k));
            steps(4);
            drive(2, 1'b0, 16'h0505, 2'd3, 4'(8 + k));
            steps(1);
        end
        settle();
        chk("sat_num_accept", 64'(na[2]), 64'd3);
        chk("sat_num_reject", 64'(nr[2]), 64'd2);
        advance();

        // asynchronous reset in the middle of WAIT
        drive(2, 1'b1, 16'h0505, 2'd3, 4'd12);
        steps(2);
        rst_ni = 1'b0;
        #1;
        model_reset();
        chk("arst_ready", 64'(rdy[2]), 64'd0);
        for (int g = 0; g < N; g++) begin
            chk($sformatf("arst_na[%0d]", g), 64'(na[g]), 64'd0);
            chk($sformatf("arst_nr[%0d]", g), 64'(nr[g]), 64'd0);
        end
        @(negedge clk_i);
        for (int g = 0; g < N; g++) drive(g, 1'b0, 16'h0, 2'd0, '0);
        rst_ni = 1'b1;
        steps(1);
        drive(2, 1'b1, 16'h0505, 2'd3, 4'd13);
        steps(3);
        settle();
        chk("post_rst_ready", 64'(rdy[2]), 64'd1);
        advance();

        // randomized traffic on every configuration
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int g = 0; g < N; g++) begin
                case ($urandom_range(0, 19))
                    0:       vld[g] = 1'b0;
                    1:       idv[g] = 4'($urandom_range(0, 3));
                    2:       ins[g] = rand_instr();
                    3:       mde[g] = 2'($urandom_range(0, 3));
                    default: vld[g] = 1'b1;
                endcase
            end
            steps(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
